// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl
//   Runtime reprogrammer for the main_pll scan chain. A request carries new
//   M (feedback) and C0 divide values; the block encodes them into a scan
//   image built from TEMPLATE, shifts the image MSB first, pulses
//   configupdate, resets the PLL and waits for lock.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   m_div, c0_div       requested divide values, 1..255 (0 is rejected)
//   busy                high whenever not IDLE
//   done, err           1-cycle completion / failure pulses
//   pll_scanclk, pll_scanclkena, pll_scandata, pll_configupdate, pll_areset
//                       reconfig port of the PLL
//   pll_scandone        PLL reports reconfig complete (registered inside)
//   pll_locked          PLL lock, asynchronous (2-flop synchronised inside)
module pll_reconfig_ctrl #(
   parameter int                  SCAN_LEN      = 144,
   parameter logic [SCAN_LEN-1:0] TEMPLATE      = '0,
   parameter int                  M_POS         = 72,
   parameter int                  C0_POS        = 36,
   parameter int                  SCANCLK_HALF  = 2,
   parameter int                  ARESET_CYCLES = 16,
   parameter int                  TIMEOUT       = 65535
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] m_div,
   input  logic [7:0] c0_div,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       pll_scanclk,
   output logic       pll_scanclkena,
   output logic       pll_scandata,
   output logic       pll_configupdate,
   output logic       pll_areset,
   input  logic       pll_scandone,
   input  logic       pll_locked
);

   localparam int HW = (SCANCLK_HALF > 1) ? $clog2(SCANCLK_HALF) : 1;
   localparam int BW = $clog2(SCAN_LEN);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int AW = (ARESET_CYCLES > 1) ? $clog2(ARESET_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SHIFT, S_UPDATE, S_WAIT_DONE, S_RESET_PLL, S_WAIT_LOCK
   } state_t;

   state_t              state;
   logic [HW-1:0]       hcnt;
   logic [BW-1:0]       bit_cnt;
   logic [TW-1:0]       tcnt;
   logic [AW-1:0]       acnt;
   logic                scandone_q;
   logic                lock_meta, lock_sync;
   logic [SCAN_LEN-1:0] image_next;
   logic [SCAN_LEN-1:0] shift_reg;
   logic                half_end;
   logic                scan_fall;

   // Counter field: {hi, lo, bypass, odd}. Divide-by-1 uses bypass.
   function automatic logic [17:0] encode(input logic [7:0] n);
      logic [8:0] n_plus;
      n_plus = {1'b0, n} + 9'd1;
      if (n == 8'd1) encode = 18'h00002;
      else           encode = {n_plus[8:1], 1'b0, n[7:1], 1'b0, n[0]};
   endfunction

   always_comb begin
      // NOTE: every bit gets a value before the field overwrites, so no latch is inferred.
      image_next                 = TEMPLATE;
      image_next[M_POS +: 18]    = encode(m_div);
      image_next[C0_POS +: 18]   = encode(c0_div);
   end

   assign half_end  = (hcnt == HW'(SCANCLK_HALF - 1));
   // Falling scanclk edge: the moment the next data bit may be presented.
   assign scan_fall = half_end && pll_scanclk;

   // NOTE: the image register needs no reset; it is always loaded on accept before use.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && req_valid)
         shift_reg <= image_next;
      else if (state == S_SHIFT && scan_fall)
         shift_reg <= {shift_reg[SCAN_LEN-2:0], 1'b0};
   end

   always_ff @(posedge clk) begin
      scandone_q <= pll_scandone;
      lock_meta  <= pll_locked;
      lock_sync  <= lock_meta;
      done       <= 1'b0;
      err        <= 1'b0;
      if (reset) begin
         state            <= S_IDLE;
         req_ready        <= 1'b1;
         busy             <= 1'b0;
         pll_scanclk      <= 1'b0;
         pll_scanclkena   <= 1'b0;
         pll_scandata     <= 1'b0;
         pll_configupdate <= 1'b0;
         pll_areset       <= 1'b0;
         hcnt             <= '0;
         bit_cnt          <= '0;
         tcnt             <= '0;
         acnt             <= '0;
         scandone_q       <= 1'b0;
         lock_meta        <= 1'b0;
         lock_sync        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  if (m_div == 8'd0 || c0_div == 8'd0) begin
                     err <= 1'b1;
                  end else begin
                     state          <= S_SHIFT;
                     req_ready      <= 1'b0;
                     busy           <= 1'b1;
                     pll_scanclkena <= 1'b1;
                     pll_scanclk    <= 1'b0;
                     hcnt           <= '0;
                     bit_cnt        <= '0;
                     pll_scandata   <= image_next[SCAN_LEN-1];
                  end
               end
            end

            S_SHIFT: begin
               if (half_end) begin
                  hcnt        <= '0;
                  pll_scanclk <= ~pll_scanclk;
                  if (pll_scanclk) begin
                     if (bit_cnt == BW'(SCAN_LEN - 1)) begin
                        pll_scanclkena   <= 1'b0;
                        pll_scandata     <= 1'b0;
                        pll_configupdate <= 1'b1;
                        state            <= S_UPDATE;
                     end else begin
                        bit_cnt      <= bit_cnt + BW'(1);
                        // Pre-shift bit below the MSB is the next bit on the wire.
                        pll_scandata <= shift_reg[SCAN_LEN-2];
                     end
                  end
               end else begin
                  hcnt <= hcnt + HW'(1);
               end
            end

            S_UPDATE: begin
               if (half_end) begin
                  hcnt        <= '0;
                  pll_scanclk <= ~pll_scanclk;
                  if (pll_scanclk) begin
                     pll_configupdate <= 1'b0;
                     tcnt             <= '0;
                     state            <= S_WAIT_DONE;
                  end
               end else begin
                  hcnt <= hcnt + HW'(1);
               end
            end

            S_WAIT_DONE: begin
               if (half_end) begin
                  hcnt        <= '0;
                  pll_scanclk <= ~pll_scanclk;
               end else begin
                  hcnt <= hcnt + HW'(1);
               end
               // The assignments below override the free-running toggle above.
               if (scandone_q) begin
                  pll_scanclk <= 1'b0;
                  pll_areset  <= 1'b1;
                  acnt        <= '0;
                  state       <= S_RESET_PLL;
               end else if (tcnt == TW'(TIMEOUT)) begin
                  pll_scanclk <= 1'b0;
                  err         <= 1'b1;
                  busy        <= 1'b0;
                  req_ready   <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end

            S_RESET_PLL: begin
               if (acnt == AW'(ARESET_CYCLES - 1)) begin
                  pll_areset <= 1'b0;
                  tcnt       <= '0;
                  state      <= S_WAIT_LOCK;
               end else begin
                  acnt <= acnt + AW'(1);
               end
            end

            S_WAIT_LOCK: begin
               if (lock_sync) begin
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
               end else if (tcnt == TW'(TIMEOUT)) begin
                  err       <= 1'b1;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
